// File: rtl/dma_endpoint_pkg.sv
// dma_endpoint_pkg: shared state encoding and direction constants for the DMA I/O endpoint
package dma_endpoint_pkg;
   typedef enum logic [2:0] {IDLE, REQ, ACK, RECOVER, DONE} ep_state_t;
   localparam logic DIR_DEV2MEM = 1'b0;
   localparam logic DIR_MEM2DEV = 1'b1;
endpackage

// File: rtl/dma_ep_fifo.sv
// dma_ep_fifo: synchronous FIFO with simultaneous push/pop and occupancy count
module dma_ep_fifo #(
   parameter int DEPTH = 8,
   parameter int DW = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push,
   input  logic                   pop,
   input  logic [DW-1:0]          din,
   output logic [DW-1:0]          dout,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   logic [DW-1:0] r_mem [DEPTH];
   logic [AW-1:0] r_wp, r_rp;
   logic [CW-1:0] r_cnt;
   logic w_push, w_pop;
   assign full   = r_cnt == CW'(DEPTH);
   assign empty  = r_cnt == '0;
   assign w_push = push & ~full;
   assign w_pop  = pop & ~empty;
   assign dout   = r_mem[r_rp];
   assign count  = r_cnt;
   // storage: written only on an accepted push, contents need no reset
   always_ff @(posedge clk) if (w_push) r_mem[r_wp] <= din;
   // pointers wrap at DEPTH; occupancy moves by accepted push minus accepted pop
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wp  <= '0;
         r_rp  <= '0;
         r_cnt <= '0;
      end else begin
         if (w_push) r_wp <= r_wp + AW'(1);
         if (w_pop) r_rp <= r_rp + AW'(1);
         r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
      end
   end
endmodule

// File: rtl/dma_io_endpoint.sv
// dma_io_endpoint: device-side DREQ/DACK responder buffering bus data in a small FIFO
module dma_io_endpoint
   import dma_endpoint_pkg::*;
#(
   parameter int DEPTH = 8,
   parameter int DW = 8
) (
   input  logic                   CLK,
   input  logic                   RESET,
   input  logic                   enable,
   input  logic                   dir,
   input  logic                   demand,
   output logic                   DREQ,
   input  logic                   DACK,
   input  logic                   IOR_N,
   input  logic                   IOW_N,
   input  logic                   EOP_N,
   input  logic [DW-1:0]          DB_in,
   output logic [DW-1:0]          DB_out,
   output logic                   DB_oe,
   input  logic                   in_valid,
   input  logic [DW-1:0]          in_data,
   output logic                   in_ready,
   output logic                   out_valid,
   output logic [DW-1:0]          out_data,
   input  logic                   out_ready,
   output logic [$clog2(DEPTH):0] count,
   output logic                   tc,
   output logic                   err
);
   localparam int CW = $clog2(DEPTH) + 1;
   ep_state_t r_state, w_state_nx;
   logic r_ior_q, r_iow_q, r_err;
   logic [DW-1:0] r_hold, w_head, w_din;
   logic w_full, w_empty, w_m2d, w_rd_edge, w_wr_edge, w_push, w_pop, w_go, w_go_nx;
   logic [CW-1:0] w_cnt_nx;
   assign w_m2d     = dir == DIR_MEM2DEV;
   assign w_rd_edge = ~w_m2d & DACK & ~r_ior_q & IOR_N;
   assign w_wr_edge = w_m2d & DACK & ~r_iow_q & IOW_N;
   assign w_push    = ~w_full & (w_m2d ? w_wr_edge : in_valid);
   assign w_pop     = ~w_empty & (w_m2d ? out_ready : w_rd_edge);
   assign w_din     = w_m2d ? r_hold : in_data;
   assign w_cnt_nx  = count + CW'(w_push) - CW'(w_pop);
   assign w_go      = enable & ~tc & (w_m2d ? ~w_full : ~w_empty);
   assign w_go_nx   = enable & (w_m2d ? w_cnt_nx != CW'(DEPTH) : w_cnt_nx != '0);
   assign DB_oe     = ~w_m2d & DACK & ~IOR_N;
   assign DB_out    = (DB_oe & ~w_empty) ? w_head : '0;
   assign out_data  = w_head;
   assign in_ready  = ~w_full & (dir == DIR_DEV2MEM);
   assign out_valid = ~w_empty & w_m2d;
   assign DREQ      = (r_state == REQ) || (r_state == ACK);
   assign tc        = r_state == DONE;
   assign err       = r_err;

   dma_ep_fifo #(.DEPTH(DEPTH), .DW(DW)) u_fifo (
      .clk(CLK), .rst(RESET), .push(w_push), .pop(w_pop), .din(w_din),
      .dout(w_head), .full(w_full), .empty(w_empty), .count(count)
   );

   // next state: disable wins, then EOP under DACK, then the request/acknowledge handshake
   always_comb begin
      w_state_nx = r_state;
      if (!enable) w_state_nx = IDLE;
      else if (DACK && !EOP_N) w_state_nx = DONE;
      else case (r_state)
         IDLE:    w_state_nx = w_go ? REQ : IDLE;
         REQ:     w_state_nx = DACK ? ACK : (w_go ? REQ : IDLE);
         ACK:     w_state_nx = (w_rd_edge | w_wr_edge) ? ((demand & w_go_nx) ? ACK : RECOVER) : (DACK ? ACK : REQ);
         RECOVER: w_state_nx = DACK ? RECOVER : IDLE;
         DONE:    w_state_nx = DONE;
         default: w_state_nx = IDLE;
      endcase
   end

   // state, strobe history for edge detection, IOW capture and sticky error
   always_ff @(posedge CLK) begin
      if (RESET) begin
         r_state <= IDLE;
         r_ior_q <= 1'b1;
         r_iow_q <= 1'b1;
         r_err   <= 1'b0;
         r_hold  <= '0;
      end else begin
         r_state <= w_state_nx;
         r_ior_q <= IOR_N;
         r_iow_q <= IOW_N;
         r_err   <= r_err | (w_rd_edge & w_empty) | (w_wr_edge & w_full);
         if (w_m2d & DACK & ~IOW_N) r_hold <= DB_in;
      end
   end
endmodule
